spectrum_band_binner: RTL and testbench

Upstream stage of the spectrum renderer. It consumes the serial magnitude stream from the FFT core (one bin per accepted beat) and sums each group of adjacent bins into one of 16 band averages. It applies peak-hold with linear decay, then publishes the packed 16×16-bit band frame together with a one-cycle done strobe. The frame is exactly what the renderer latches as its FFT data/done pair, and it stays stable between strobes so the renderer may sample it at any later time.

---
 rtl/spectrum_band_binner.sv | 108 ++++++++++
 tb/tb_spectrum_band_binner.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/spectrum_band_binner.sv
// Bins the serial FFT magnitude stream into 16 band averages with peak-hold decay
// and publishes a stable packed frame plus a one-cycle done strobe.
module spectrum_band_binner #(
  parameter int          BINS_PER_BAND = 8,
  parameter logic [15:0] DECAY         = 16'd256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [15:0]       i_mag,
  input  logic              i_last,
  output logic              o_ready,
  output logic [15:0][15:0] o_fft_data,
  output logic              o_fft_done,
  output logic              o_drop
);

  localparam int NBINS = 16 * BINS_PER_BAND;
  localparam int SH    = $clog2(BINS_PER_BAND);
  localparam int AW    = 16 + SH;
  localparam int CW    = $clog2(NBINS);

  typedef enum logic {S_ACC = 1'b0, S_PUBLISH = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  acc [16];
  logic [CW-1:0]  bin_cnt;
  logic           ovf;
  logic [3:0]     band;
  logic           accept, at_end;
  logic [15:0]    avg_w [16];
  logic [15:0]    dec_w [16];
  logic [15:0][15:0] pub;

  // Handshake: a beat transfers on a rising edge where i_valid && o_ready; the
  // source holds i_mag/i_last stable while i_valid is high and o_ready is low.
  assign accept = i_valid && o_ready;
  assign at_end = (bin_cnt == CW'(NBINS - 1));
  assign band   = bin_cnt[CW-1:SH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_ACC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:     if (accept && i_last && at_end && !ovf) state_nxt = S_PUBLISH;
      S_PUBLISH: state_nxt = S_ACC;
      default:   state_nxt = S_ACC;
    endcase
  end

  always_comb begin
    o_ready = (state == S_ACC);
  end

  // New peak-hold value per band: the larger of this frame's average and the decayed peak.
  always_comb begin
    avg_w = '{default: '0};
    dec_w = '{default: '0};
    pub   = '0;
    for (int b = 0; b < 16; b++) begin
      avg_w[b] = acc[b][SH +: 16];
      dec_w[b] = (o_fft_data[b] > DECAY) ? (o_fft_data[b] - DECAY) : 16'd0;
      pub[b]   = (avg_w[b] > dec_w[b]) ? avg_w[b] : dec_w[b];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < 16; b++) acc[b] <= '0;
      bin_cnt    <= '0;
      ovf        <= 1'b0;
      o_fft_data <= '0;
      o_fft_done <= 1'b0;
      o_drop     <= 1'b0;
    end else begin
      o_fft_done <= 1'b0;
      o_drop     <= 1'b0;
      if (state == S_PUBLISH) begin
        o_fft_data <= pub;
        o_fft_done <= 1'b1;
        for (int b = 0; b < 16; b++) acc[b] <= '0;
        bin_cnt    <= '0;
      end else if (accept) begin
        if (i_last) begin
          if (at_end && !ovf) begin
            // Final sample of a good frame; bin_cnt is cleared on the publish edge.
            acc[band] <= acc[band] + AW'(i_mag);
          end else begin
            for (int b = 0; b < 16; b++) acc[b] <= '0;
            bin_cnt <= '0;
            ovf     <= 1'b0;
            o_drop  <= 1'b1;
          end
        end else if (ovf || at_end) begin
          ovf <= 1'b1;
        end else begin
          acc[band] <= acc[band] + AW'(i_mag);
          bin_cnt   <= bin_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spectrum_band_binner.sv
// Directed self-checking bench for spectrum_band_binner at default parameters.
module tb_spectrum_band_binner;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic [15:0]       i_mag = '0;
  logic              i_last = 1'b0;
  logic              o_ready;
  logic [15:0][15:0] o_fft_data;
  logic              o_fft_done;
  logic              o_drop;

  int n_checks = 0;
  int n_fail   = 0;

  spectrum_band_binner dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_mag      (i_mag),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .o_fft_data (o_fft_data),
    .o_fft_done (o_fft_done),
    .o_drop     (o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [15:0][15:0] f;
    for (int b = 0; b < 16; b++) f[b] = v;
    return f;
  endfunction

  function automatic logic [255:0] ramp_exp();
    logic [15:0][15:0] f;
    for (int b = 0; b < 16; b++) f[b] = 16'(4096 * b + 1792);
    return f;
  endfunction

  // One beat; waits (bounded) for o_ready, returns #1 after the accepting edge.
  task automatic beat(input logic [15:0] mag, input logic last);
    int tries = 0;
    i_valid = 1'b1;
    i_mag   = mag;
    i_last  = last;
    @(negedge i_clk);
    while (!o_ready && tries < 4) begin
      tries++;
      @(negedge i_clk);
    end
    if (!o_ready) chk("beat_ready_timeout", o_ready, 1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic frame(input int n, input bit ramp, input logic [15:0] v);
    for (int i = 0; i < n; i++) beat(ramp ? 16'(i * 512) : v, (i == n - 1));
  endtask

  task automatic check_publish(input string tag, input logic [255:0] exp);
    chk({tag, "_ready_low"}, o_ready, 0);
    chk({tag, "_done_early"}, o_fft_done, 0);
    @(posedge i_clk); #1;
    chk({tag, "_done"}, o_fft_done, 1);
    chk({tag, "_ready_back"}, o_ready, 1);
    chk({tag, "_data"}, o_fft_data, exp);
    @(posedge i_clk); #1;
    chk({tag, "_done_clear"}, o_fft_done, 0);
    chk({tag, "_data_hold"}, o_fft_data, exp);
  endtask

  task automatic check_drop(input string tag, input logic [255:0] exp);
    chk({tag, "_drop"}, o_drop, 1);
    chk({tag, "_no_done"}, o_fft_done, 0);
    chk({tag, "_ready"}, o_ready, 1);
    @(posedge i_clk); #1;
    chk({tag, "_drop_clear"}, o_drop, 0);
    chk({tag, "_no_done2"}, o_fft_done, 0);
    chk({tag, "_data_kept"}, o_fft_data, exp);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_data", o_fft_data, 0);
    chk("rst_done", o_fft_done, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_ready", o_ready, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    frame(128, 1'b0, 16'd1000);
    check_publish("f1000", fill(16'd1000));

    frame(128, 1'b0, 16'd0);
    check_publish("decay744", fill(16'd744));
    frame(128, 1'b0, 16'd0);
    check_publish("decay488", fill(16'd488));
    frame(128, 1'b0, 16'd0);
    check_publish("decay232", fill(16'd232));
    frame(128, 1'b0, 16'd0);
    check_publish("decay0", fill(16'd0));
    frame(128, 1'b0, 16'd0);
    check_publish("decay0_hold", fill(16'd0));

    frame(128, 1'b1, 16'd0);
    check_publish("ramp", ramp_exp());

    frame(50, 1'b0, 16'd5);
    check_drop("short", ramp_exp());
    // Bands 0..14 take the new average; band 15's decayed ramp peak (62976) still wins.
    begin
      logic [15:0][15:0] e;
      e = fill(16'hF000);
      e[15] = 16'd62976;
      frame(128, 1'b0, 16'hF000);
      check_publish("after_short", e);

      frame(140, 1'b0, 16'hFFFF);
      check_drop("long", e);
    end
    frame(128, 1'b0, 16'hFFFF);
    check_publish("after_long", fill(16'hFFFF));

    for (int i = 0; i < 63; i++) beat(16'd777, 1'b0);
    i_valid = 1'b1;
    i_mag   = 16'd777;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_data", o_fft_data, 0);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_done", o_fft_done, 0);
    chk("midrst_drop", o_drop, 0);
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("postrst_drop", o_drop, 0);
    frame(128, 1'b0, 16'd300);
    check_publish("f300", fill(16'd300));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
